fetch_unit: RTL and testbench

//  Front-end fetch stage. Holds the architectural fetch PC, issues instruction-memory reads and buffers
//  the returned words for decode. Sits directly downstream of the jump/branch unit and consumes its
//  new_pc / ctrl_fetch / halt outputs. A redirect discards all buffered and in-flight wrong-path words.

---
 rtl/fetch_unit.sv | 195 +++++++++++++++++++
 tb/tb_fetch_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Front-end fetch stage: owns the fetch PC, issues in-order instruction-memory reads and
// buffers returned words for decode; a redirect discards buffered and in-flight wrong-path words.

module fetch_unit_chk #(
  parameter int BUF_DEPTH = 2
) (
  input logic                         clock,
  input logic                         reset,
  input logic                         buf_push_i,
  input logic                         buf_pop_i,
  input logic [$clog2(BUF_DEPTH):0]   buf_cnt_i,
  input logic                         pend_push_i,
  input logic                         pend_pop_i,
  input logic [$clog2(BUF_DEPTH):0]   inflight_i,
  input logic                         rsp_valid_i
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

  a_buf_no_overflow: assert property (@(posedge clock) disable iff (!reset)
    (buf_push_i && !buf_pop_i) |-> (buf_cnt_i < DEPTH_C))
    else $error("fetch_unit: instruction buffer overflow");

  a_pend_no_overflow: assert property (@(posedge clock) disable iff (!reset)
    (pend_push_i && !pend_pop_i) |-> (inflight_i < DEPTH_C))
    else $error("fetch_unit: pending-address FIFO overflow");

  a_rsp_has_request: assert property (@(posedge clock) disable iff (!reset)
    rsp_valid_i |-> (inflight_i != CW'(0)))
    else $error("fetch_unit: response with no request in flight");
endmodule

module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_fetch,
  input  logic [31:0] new_pc,
  input  logic        halt,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [0:0]    ST_RUN   = 1'b0;
  localparam logic [0:0]    ST_FLUSH = 1'b1;
  localparam logic [CW:0]   DEPTH_W  = (CW+1)'(BUF_DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW-1:0] PTR_ZERO = PW'(0);

  logic [0:0]    state_q, state_d;
  logic          alive_q;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] buf_cnt_q, buf_cnt_d;
  logic [PW-1:0] pend_rd_q, pend_rd_d, pend_wr_q, pend_wr_d;
  logic [PW-1:0] buf_rd_q, buf_rd_d, buf_wr_q, buf_wr_d;
  logic [31:0]   pend_addr_q [BUF_DEPTH];
  logic [31:0]   buf_data_q  [BUF_DEPTH];
  logic [31:0]   buf_pc_q    [BUF_DEPTH];

  logic          credit_s;
  logic          issue_s;
  logic          pop_s;
  logic          pend_push_s;
  logic          buf_push_s;
  logic [CW-1:0] rsp_left_s;

  // Handshake-facing outputs; alive_q holds off the first request until one edge after reset release.
  always_comb begin
    credit_s       = ({1'b0, inflight_q} + {1'b0, buf_cnt_q}) < DEPTH_W;
    imem_req_valid = alive_q & (state_q == ST_RUN) & ~halt & ~ctrl_fetch & credit_s;
    imem_req_addr  = fetch_pc_q;
    inst_valid     = (buf_cnt_q != CNT_ZERO) & ~halt & ~ctrl_fetch;
    inst_data      = buf_data_q[buf_rd_q];
    inst_pc        = buf_pc_q[buf_rd_q];
    issue_s        = imem_req_valid & imem_req_ready;
    pop_s          = inst_valid & inst_ready;
    rsp_left_s     = (imem_rsp_valid && (inflight_q != CNT_ZERO)) ? inflight_q - CNT_ONE : inflight_q;
  end

  // Next-state: redirect overrides everything, otherwise RUN moves words and FLUSH drains stale responses.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    inflight_d  = inflight_q;
    drop_d      = drop_q;
    buf_cnt_d   = buf_cnt_q;
    pend_rd_d   = pend_rd_q;
    pend_wr_d   = pend_wr_q;
    buf_rd_d    = buf_rd_q;
    buf_wr_d    = buf_wr_q;
    pend_push_s = 1'b0;
    buf_push_s  = 1'b0;
    if (ctrl_fetch) begin
      fetch_pc_d = {new_pc[31:2], 2'b00};
      buf_cnt_d  = CNT_ZERO;
      pend_rd_d  = PTR_ZERO;
      pend_wr_d  = PTR_ZERO;
      buf_rd_d   = PTR_ZERO;
      buf_wr_d   = PTR_ZERO;
      drop_d     = rsp_left_s;
      inflight_d = rsp_left_s;
      state_d    = (rsp_left_s != CNT_ZERO) ? ST_FLUSH : ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          pend_push_s = issue_s;
          buf_push_s  = imem_rsp_valid;
          fetch_pc_d  = issue_s ? fetch_pc_q + 32'd4 : fetch_pc_q;
          pend_wr_d   = issue_s ? pend_wr_q + PTR_ONE : pend_wr_q;
          pend_rd_d   = imem_rsp_valid ? pend_rd_q + PTR_ONE : pend_rd_q;
          buf_wr_d    = imem_rsp_valid ? buf_wr_q + PTR_ONE : buf_wr_q;
          buf_rd_d    = pop_s ? buf_rd_q + PTR_ONE : buf_rd_q;
          inflight_d  = inflight_q + (issue_s ? CNT_ONE : CNT_ZERO)
                                   - (imem_rsp_valid ? CNT_ONE : CNT_ZERO);
          buf_cnt_d   = buf_cnt_q + (imem_rsp_valid ? CNT_ONE : CNT_ZERO)
                                  - (pop_s ? CNT_ONE : CNT_ZERO);
        end
        ST_FLUSH: begin
          drop_d     = (imem_rsp_valid && (drop_q != CNT_ZERO)) ? drop_q - CNT_ONE : drop_q;
          inflight_d = (imem_rsp_valid && (inflight_q != CNT_ZERO)) ? inflight_q - CNT_ONE : inflight_q;
          state_d    = ((drop_q == CNT_ZERO) || (imem_rsp_valid && (drop_q == CNT_ONE)))
                       ? ST_RUN : ST_FLUSH;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  // State and storage registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_RUN;
      alive_q    <= 1'b0;
      fetch_pc_q <= RESET_PC;
      inflight_q <= CNT_ZERO;
      drop_q     <= CNT_ZERO;
      buf_cnt_q  <= CNT_ZERO;
      pend_rd_q  <= PTR_ZERO;
      pend_wr_q  <= PTR_ZERO;
      buf_rd_q   <= PTR_ZERO;
      buf_wr_q   <= PTR_ZERO;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        pend_addr_q[i] <= 32'h0000_0000;
        buf_data_q[i]  <= 32'h0000_0000;
        buf_pc_q[i]    <= 32'h0000_0000;
      end
    end else begin
      state_q    <= state_d;
      alive_q    <= 1'b1;
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      buf_cnt_q  <= buf_cnt_d;
      pend_rd_q  <= pend_rd_d;
      pend_wr_q  <= pend_wr_d;
      buf_rd_q   <= buf_rd_d;
      buf_wr_q   <= buf_wr_d;
      if (pend_push_s) begin
        pend_addr_q[pend_wr_q] <= fetch_pc_q;
      end
      if (buf_push_s) begin
        buf_data_q[buf_wr_q] <= imem_rsp_data;
        buf_pc_q[buf_wr_q]   <= pend_addr_q[pend_rd_q];
      end
    end
  end

  fetch_unit_chk #(.BUF_DEPTH(BUF_DEPTH)) u_chk (
    .clock       (clock),
    .reset       (reset),
    .buf_push_i  (buf_push_s),
    .buf_pop_i   (pop_s),
    .buf_cnt_i   (buf_cnt_q),
    .pend_push_i (pend_push_s),
    .pend_pop_i  (buf_push_s),
    .inflight_i  (inflight_q),
    .rsp_valid_i (imem_rsp_valid)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based memory and decode model, directed scenarios then random traffic.

module tb_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int          DEPTH  = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_fetch;
  logic [31:0] new_pc;
  logic        halt;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  always #5 clock = ~clock;

  fetch_unit #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_fetch     (ctrl_fetch),
    .new_pc         (new_pc),
    .halt           (halt),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Memory model: accepted requests in order, each with the cycle its data may return and a
  // flag saying it was overtaken by a redirect. bq holds live words waiting for decode.
  logic [31:0] mq_addr [$];
  int          mq_rdy  [$];
  bit          mq_stale[$];
  logic [31:0] bq      [$];
  logic [31:0] dlog    [$];
  logic [31:0] exp_issue;
  bit          alive;
  int          cyc = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          dut_issued = 0;
  int          mark;

  function automatic logic [31:0] memdata(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic bit has_stale();
    foreach (mq_stale[i]) if (mq_stale[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_log(input string tag, input int idx, input logic [31:0] exp);
    logic [31:0] got;
    got = (idx < dlog.size()) ? dlog[idx] : 32'hxxxx_xxxx;
    chk(tag, got, exp);
  endtask

  task automatic clear_model();
    mq_addr.delete(); mq_rdy.delete(); mq_stale.delete(); bq.delete();
    exp_issue = RST_PC;
    alive = 1'b0;
  endtask

  task automatic idle_inputs();
    ctrl_fetch = 1'b0; new_pc = 32'h0; halt = 1'b0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; inst_ready = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_valid"}, {31'b0, imem_req_valid}, 32'h0);
    chk({tag, "_inst_valid"}, {31'b0, inst_valid}, 32'h0);
    chk({tag, "_inst_data"}, inst_data, 32'h0);
    chk({tag, "_inst_pc"}, inst_pc, 32'h0);
    chk({tag, "_req_addr"}, imem_req_addr, RST_PC);
  endtask

  // One clock of stimulus: drive at negedge, compare comb outputs, advance the model at posedge.
  task automatic step(input bit h, input bit cf, input logic [31:0] npc,
                      input bit rr, input bit ir, input bit ren);
    bit rsp, erv, eiv, acc, pop, st;
    logic [31:0] a;
    @(negedge clock);
    halt = h; ctrl_fetch = cf; new_pc = npc; imem_req_ready = rr; inst_ready = ir;
    rsp = ren && (mq_addr.size() != 0) && (mq_rdy[0] <= cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? memdata(mq_addr[0]) : $urandom();
    #1;
    erv = alive && !h && !cf && !has_stale() && ((mq_addr.size() + bq.size()) < DEPTH);
    eiv = (bq.size() != 0) && !h && !cf;
    chk("req_valid", {31'b0, imem_req_valid}, {31'b0, erv});
    if (erv) chk("req_addr", imem_req_addr, exp_issue);
    chk("inst_valid", {31'b0, inst_valid}, {31'b0, eiv});
    if (eiv) begin
      chk("inst_pc", inst_pc, bq[0]);
      chk("inst_data", inst_data, memdata(bq[0]));
    end
    acc = erv && rr;
    pop = eiv && ir;
    if (imem_req_valid && rr) dut_issued++;
    if (pop) dlog.push_back(inst_pc);
    @(posedge clock);
    if (pop) void'(bq.pop_front());
    if (rsp) begin
      a  = mq_addr.pop_front();
      void'(mq_rdy.pop_front());
      st = mq_stale.pop_front();
      if (!st && !cf) bq.push_back(a);
    end
    if (acc) begin
      mq_addr.push_back(exp_issue);
      mq_rdy.push_back(cyc + $urandom_range(lat_max, lat_min));
      mq_stale.push_back(1'b0);
      exp_issue = exp_issue + 32'd4;
    end
    if (cf) begin
      foreach (mq_stale[i]) mq_stale[i] = 1'b1;
      bq.delete();
      exp_issue = {npc[31:2], 2'b00};
    end
    alive = 1'b1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic redirect(input logic [31:0] npc);
    step(1'b0, 1'b1, npc, 1'b1, 1'b1, 1'b1);
    dut_issued = 0;
    mark = dlog.size();
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    clear_model();
    @(negedge clock); #1;
    chk_reset_outputs("reset");
    @(posedge clock); #1;
    reset = 1'b1;

    // Reset release: in-order delivery from RESET_PC with a one-cycle memory.
    mark = dlog.size();
    run(14);
    chk_log("t1_pc0", mark, 32'h0000_0100);
    chk_log("t1_pc1", mark + 1, 32'h0000_0104);
    chk_log("t1_pc2", mark + 2, 32'h0000_0108);

    // Decode stalled: the credit rule allows exactly DEPTH requests.
    redirect(32'h0000_0000);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    chk("t2_issued", dut_issued, 32'd2);
    run(6);
    chk_log("t2_pc0", mark, 32'h0000_0000);
    chk_log("t2_pc1", mark + 1, 32'h0000_0004);

    // Two slow reads in flight, then redirect: both discarded.
    lat_min = 10; lat_max = 10;
    redirect(32'h0000_0200);
    run(5);
    chk("t3_inflight", dut_issued, 32'd2);
    lat_min = 1; lat_max = 1;
    redirect(32'h0000_0040);
    run(25);
    chk_log("t3_pc0", mark, 32'h0000_0040);
    chk_log("t3_pc1", mark + 1, 32'h0000_0044);

    // Halt with a response in flight.
    lat_min = 3; lat_max = 3;
    redirect(32'h0000_0300);
    for (int i = 0; i < 10 && dut_issued == 0; i++) run(1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    lat_min = 1; lat_max = 1;
    run(15);
    chk_log("t4_pc0", mark, 32'h0000_0300);
    chk_log("t4_pc1", mark + 1, 32'h0000_0304);

    // Redirect coinciding with halt and a response; target low bits are ignored.
    lat_min = 3; lat_max = 3;
    redirect(32'h0000_0500);
    for (int i = 0; i < 12 && dut_issued < 2; i++) run(1);
    for (int i = 0; i < 10; i++) begin
      if ((mq_addr.size() != 0) && (mq_rdy[0] <= cyc)) break;
      step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    end
    step(1'b1, 1'b1, 32'h0000_0603, 1'b1, 1'b1, 1'b1);
    mark = dlog.size();
    lat_min = 1; lat_max = 1;
    run(20);
    chk_log("t5_pc0", mark, 32'h0000_0600);
    chk_log("t5_pc1", mark + 1, 32'h0000_0604);

    // PC wrap across the top of the address space.
    redirect(32'hFFFF_FFF8);
    run(20);
    chk_log("t6_pc0", mark, 32'hFFFF_FFF8);
    chk_log("t6_pc1", mark + 1, 32'hFFFF_FFFC);
    chk_log("t6_pc2", mark + 2, 32'h0000_0000);

    // Reset asserted while stale reads are still being drained.
    lat_min = 6; lat_max = 6;
    redirect(32'h0000_0700);
    run(3);
    step(1'b0, 1'b1, 32'h0000_0080, 1'b1, 1'b1, 1'b1);
    @(negedge clock); #1;
    idle_inputs();
    reset = 1'b0;
    #1;
    chk_reset_outputs("midflush_reset");
    clear_model();
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b1;
    lat_min = 1; lat_max = 1;
    mark = dlog.size();
    run(10);
    chk_log("post_reset_pc0", mark, RST_PC);

    // Random traffic against the model.
    lat_min = 1; lat_max = 4;
    mark = dlog.size();
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(9, 0) == 0, $urandom_range(19, 0) == 0, $urandom(),
           $urandom_range(9, 0) < 7, $urandom_range(9, 0) < 7, $urandom_range(9, 0) < 8);
    end
    chk("rand_progress", {31'b0, dlog.size() > mark + 100}, 32'h1);
    run(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
